// File: rtl/bist_resp_compactor_pkg.sv
// Shared definitions for the scan-BIST response path: FSM states, MISR defaults and the
// MISR step function also used by the TPG-side checker.
package bist_resp_compactor_pkg;

  localparam int unsigned DefaultMisrW = 16;
  localparam logic [31:0] DefaultPoly  = 32'h0000_002D;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StCapture,
    StUnload,
    StDone
  } bist_state_e;

  // Galois MISR step on a right-aligned value of up to 32 bits; result masked to width.
  function automatic logic [31:0] misr_step(input logic [31:0] sig,
                                            input logic [31:0] poly,
                                            input logic [31:0] din,
                                            input int unsigned width);
    logic [31:0] mask;
    logic [4:0]  msb;
    logic        fb;
    mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    msb  = 5'(width - 1);
    fb   = sig[msb];
    return ((sig << 1) ^ (fb ? poly : 32'd0) ^ din) & mask;
  endfunction

endpackage

// File: rtl/bist_resp_compactor_if.sv
// Handshake/data bundle between the BIST sequencer side (master) and the compactor (slave).
interface bist_resp_compactor_if #(
  parameter int unsigned NChains   = 7,
  parameter int unsigned MisrW     = 16,
  parameter int unsigned NPatterns = 1000
);
  localparam int unsigned PatCntW = $clog2(NPatterns + 1);

  logic                bist_en;
  logic [NChains-1:0]  so_chain;
  logic                scan_en;
  logic                tpg_en;
  logic [MisrW-1:0]    misr_sig;
  logic [PatCntW-1:0]  pat_cnt;
  logic                bist_done;
  logic                bist_pass;

  modport master (
    output bist_en, so_chain,
    input  scan_en, tpg_en, misr_sig, pat_cnt, bist_done, bist_pass
  );

  modport slave (
    input  bist_en, so_chain,
    output scan_en, tpg_en, misr_sig, pat_cnt, bist_done, bist_pass
  );
endinterface

// File: rtl/bist_resp_compactor_misr.sv
// Multiple-input signature register: init loads the seed, en compacts din into the signature.
module bist_misr
  import bist_resp_compactor_pkg::*;
#(
  parameter int unsigned      NChains = 7,
  parameter int unsigned      MisrW   = DefaultMisrW,
  parameter logic [MisrW-1:0] Poly    = MisrW'(DefaultPoly),
  parameter logic [MisrW-1:0] Seed    = '0
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               init_i,
  input  logic [NChains-1:0] din_i,
  output logic [MisrW-1:0]   sig_o
);

  logic [MisrW-1:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (init_i) begin
      sig_d = Seed;
    end else if (en_i) begin
      sig_d = MisrW'(misr_step(32'(sig_q), 32'(Poly), 32'(din_i), MisrW));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= Seed;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/bist_resp_compactor.sv
// Scan-BIST response stage: sequences load/capture/unload, drives scan_en/tpg_en and
// compacts scan-out data into a MISR, checking the final signature against a golden value.
module bist_resp_compactor
  import bist_resp_compactor_pkg::*;
#(
  parameter int unsigned      NChains   = 7,
  parameter int unsigned      ChainLen  = 33,
  parameter int unsigned      NPatterns = 1000,
  parameter int unsigned      MisrW     = DefaultMisrW,
  parameter logic [MisrW-1:0] Poly      = MisrW'(DefaultPoly),
  parameter logic [MisrW-1:0] Seed      = '0,
  parameter logic [MisrW-1:0] Golden    = '0
) (
  input  logic                  CK,
  input  logic                  COMP_reset_n,
  bist_resp_compactor_if.slave  bus
);

  localparam int unsigned        PatCntW   = $clog2(NPatterns + 1);
  localparam int unsigned        ShiftW    = (ChainLen > 1) ? $clog2(ChainLen) : 1;
  localparam logic [ShiftW-1:0]  ShiftLast = ShiftW'(ChainLen - 1);
  localparam logic [PatCntW-1:0] PatMax    = PatCntW'(NPatterns);

  bist_state_e        state_q, state_d;
  logic [ShiftW-1:0]  shift_cnt_q, shift_cnt_d;
  logic [PatCntW-1:0] pat_cnt_q, pat_cnt_d;
  logic               pass_q, pass_d;
  logic               misr_en, misr_init, shift_last;
  logic [MisrW-1:0]   misr_sig, misr_next;

  // Signature after the current cycle's compaction; sampled on the edge entering DONE.
  assign misr_next  = MisrW'(misr_step(32'(misr_sig), 32'(Poly), 32'(bus.so_chain), MisrW));
  assign shift_last = (shift_cnt_q == ShiftLast);

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q + ShiftW'(1);
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass_q;
    misr_en     = 1'b0;
    misr_init   = 1'b0;

    unique case (state_q)
      StIdle: begin
        misr_init   = 1'b1;
        pat_cnt_d   = '0;
        shift_cnt_d = '0;
        pass_d      = 1'b0;
        if (bus.bist_en) state_d = StLoad;
      end
      StLoad: begin
        // The first load shifts out uninitialised flops, so it is never compacted.
        misr_en = (pat_cnt_q != '0);
        if (shift_last) begin
          pat_cnt_d = (pat_cnt_q == PatMax) ? pat_cnt_q : pat_cnt_q + PatCntW'(1);
          state_d   = StCapture;
        end
      end
      StCapture: begin
        state_d = (pat_cnt_q < PatMax) ? StLoad : StUnload;
      end
      StUnload: begin
        misr_en = 1'b1;
        if (shift_last) begin
          state_d = StDone;
          pass_d  = (misr_next == Golden);
        end
      end
      StDone: begin
        if (!bus.bist_en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (!bus.bist_en && (state_q inside {StLoad, StCapture, StUnload})) begin
      state_d = StIdle;
      misr_en = 1'b0;
      pass_d  = 1'b0;
    end

    if (shift_last || (state_d != state_q)) shift_cnt_d = '0;
  end

  always_ff @(posedge CK or negedge COMP_reset_n) begin
    if (!COMP_reset_n) begin
      state_q     <= StIdle;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      pass_q      <= pass_d;
    end
  end

  bist_misr #(
    .NChains (NChains),
    .MisrW   (MisrW),
    .Poly    (Poly),
    .Seed    (Seed)
  ) u_misr (
    .clk_i  (CK),
    .rst_ni (COMP_reset_n),
    .en_i   (misr_en),
    .init_i (misr_init),
    .din_i  (bus.so_chain),
    .sig_o  (misr_sig)
  );

  assign bus.scan_en   = (state_q == StLoad) || (state_q == StUnload);
  assign bus.tpg_en    = (state_q == StLoad);
  assign bus.bist_done = (state_q == StDone);
  assign bus.bist_pass = pass_q && (state_q == StDone);
  assign bus.pat_cnt   = pat_cnt_q;
  assign bus.misr_sig  = misr_sig;

endmodule

// File: tb/tb_bist_resp_compactor.sv
// Directed bench: two compactors (golden 0 and 8'h05) share one stimulus stream.
module tb_bist_resp_compactor;

  logic       CK;
  logic       COMP_reset_n;
  logic       bist_en;
  logic [6:0] so;
  int         n_checks;
  int         n_errors;

  bist_resp_compactor_if #(.NChains(7), .MisrW(8), .NPatterns(2)) bus_a ();
  bist_resp_compactor_if #(.NChains(7), .MisrW(8), .NPatterns(2)) bus_b ();

  assign bus_a.bist_en  = bist_en;
  assign bus_a.so_chain = so;
  assign bus_b.bist_en  = bist_en;
  assign bus_b.so_chain = so;

  bist_resp_compactor #(
    .NChains(7), .ChainLen(3), .NPatterns(2), .MisrW(8),
    .Poly(8'h1D), .Seed(8'h00), .Golden(8'h00)
  ) dut_a (
    .CK           (CK),
    .COMP_reset_n (COMP_reset_n),
    .bus          (bus_a)
  );

  bist_resp_compactor #(
    .NChains(7), .ChainLen(3), .NPatterns(2), .MisrW(8),
    .Poly(8'h1D), .Seed(8'h00), .Golden(8'h05)
  ) dut_b (
    .CK           (CK),
    .COMP_reset_n (COMP_reset_n),
    .bus          (bus_b)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One uninterrupted run; so_chain = v during cycles lo..hi counted from the first LOAD cycle.
  task automatic run_full(input string tag, input logic [6:0] v, input int lo, input int hi,
                          input logic [7:0] exp_misr);
    logic [10:0] scan_seen;
    logic [10:0] tpg_seen;
    scan_seen = '0;
    tpg_seen  = '0;
    bist_en = 1'b1;
    so      = '0;
    @(posedge CK); #1;
    for (int k = 0; k < 11; k++) begin
      so = (k >= lo && k <= hi) ? v : 7'h00;
      @(negedge CK);
      scan_seen[k] = bus_a.scan_en;
      tpg_seen[k]  = bus_a.tpg_en;
      if (k == 0) begin
        check({tag, " start pat_cnt"}, 32'(bus_a.pat_cnt), 32'd0);
        check({tag, " start misr"}, 32'(bus_a.misr_sig), 32'h00);
      end
      if (k == 3) check({tag, " capture pat_cnt"}, 32'(bus_a.pat_cnt), 32'd1);
      if (k == 10) check({tag, " done early"}, 32'(bus_a.bist_done), 32'd0);
      @(posedge CK); #1;
    end
    so = '0;
    check({tag, " scan_en seq"}, 32'(scan_seen), 32'h777);
    check({tag, " tpg_en seq"}, 32'(tpg_seen), 32'h077);
    check({tag, " done a"}, 32'(bus_a.bist_done), 32'd1);
    check({tag, " done b"}, 32'(bus_b.bist_done), 32'd1);
    check({tag, " misr"}, 32'(bus_a.misr_sig), 32'(exp_misr));
    check({tag, " misr b"}, 32'(bus_b.misr_sig), 32'(exp_misr));
    check({tag, " pass a"}, 32'(bus_a.bist_pass), 32'(exp_misr == 8'h00));
    check({tag, " pass b"}, 32'(bus_b.bist_pass), 32'(exp_misr == 8'h05));
    check({tag, " final pat_cnt"}, 32'(bus_a.pat_cnt), 32'd2);
    @(posedge CK); #1;
    check({tag, " done hold"}, 32'(bus_a.bist_done), 32'd1);
    bist_en = 1'b0;
    @(posedge CK); #1;
    check({tag, " idle done"}, 32'(bus_b.bist_done), 32'd0);
    check({tag, " idle pass"}, 32'(bus_a.bist_pass), 32'd0);
    check({tag, " idle scan_en"}, 32'(bus_a.scan_en), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    COMP_reset_n = 1'b0;
    bist_en      = 1'b0;
    so           = '0;
    #3;
    check("rst scan_en", 32'(bus_a.scan_en), 32'd0);
    check("rst tpg_en", 32'(bus_a.tpg_en), 32'd0);
    check("rst misr", 32'(bus_a.misr_sig), 32'h00);
    check("rst pat_cnt", 32'(bus_a.pat_cnt), 32'd0);
    check("rst done", 32'(bus_a.bist_done), 32'd0);
    check("rst pass", 32'(bus_a.bist_pass), 32'd0);
    #19 COMP_reset_n = 1'b1;
    @(posedge CK); #1;

    // Async reset in the second LOAD, once the MISR and pat_cnt are non-zero.
    bist_en = 1'b1;
    @(posedge CK); #1;
    for (int k = 0; k < 5; k++) begin
      so = (k == 4) ? 7'h01 : 7'h00;
      @(posedge CK); #1;
    end
    so = '0;
    check("pre-rst misr", 32'(bus_a.misr_sig), 32'h01);
    check("pre-rst pat_cnt", 32'(bus_a.pat_cnt), 32'd1);
    check("pre-rst scan_en", 32'(bus_a.scan_en), 32'd1);
    #2 COMP_reset_n = 1'b0;
    #1;
    check("async rst scan_en", 32'(bus_a.scan_en), 32'd0);
    check("async rst tpg_en", 32'(bus_a.tpg_en), 32'd0);
    check("async rst misr", 32'(bus_a.misr_sig), 32'h00);
    check("async rst pat_cnt", 32'(bus_a.pat_cnt), 32'd0);
    bist_en = 1'b0;
    @(negedge CK);
    #2 COMP_reset_n = 1'b1;
    @(posedge CK); #1;
    check("post-rst idle", 32'(bus_a.scan_en), 32'd0);

    // Abort during the second LOAD, then a fresh run.
    bist_en = 1'b1;
    @(posedge CK); #1;
    for (int k = 0; k < 5; k++) begin
      so = (k == 4) ? 7'h01 : 7'h00;
      @(posedge CK); #1;
    end
    bist_en = 1'b0;
    so      = '0;
    @(negedge CK);
    check("abort same cycle scan_en", 32'(bus_a.scan_en), 32'd1);
    @(posedge CK); #1;
    @(negedge CK);
    check("abort scan_en", 32'(bus_a.scan_en), 32'd0);
    check("abort tpg_en", 32'(bus_a.tpg_en), 32'd0);
    check("abort done", 32'(bus_a.bist_done), 32'd0);
    @(posedge CK); #1;
    run_full("rerun unload hit", 7'h01, 8, 8, 8'h04);

    run_full("zeros", 7'h00, 0, 10, 8'h00);
    run_full("first load gated", 7'h7F, 0, 2, 8'h00);
    run_full("unload hit", 7'h01, 8, 8, 8'h04);
    run_full("load1 hit", 7'h01, 4, 4, 8'h20);
    run_full("unload poly fb", 7'h7F, 8, 8, 8'hE1);
    run_full("capture ignored", 7'h7F, 3, 3, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
